// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - in-order predicted-branch log with mispredict redirect/flush
module branch_redirect_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          pred_valid,
  input  logic          pred_taken,
  input  logic [AW-1:0] pred_pc,
  input  logic [AW-1:0] pred_target,
  input  logic [1:0]    res_code,
  output logic          redirect,
  output logic [AW-1:0] redirect_pc,
  output logic          flush,
  output logic          stall_req,
  output logic          err,
  output logic [CW-1:0] br_cnt,
  output logic [CW-1:0] miss_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] alt_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic          resolve;
  logic          do_pop;
  logic          mispredict;
  logic          push_req;
  logic          push_write;
  logic          err_set;
  logic [AW-1:0] alt_pc;

  // The alternate PC is what fetch needs if the prediction turns out wrong.
  assign alt_pc     = pred_taken ? (pred_pc + AW'(4)) : pred_target;

  assign resolve    = !stall && (res_code != 2'b10);
  assign do_pop     = resolve && (count != '0);
  assign mispredict = do_pop && res_code[0];

  // Pushes during a redirect cycle are wrong-path and silently dropped.
  assign push_req   = !stall && pred_valid && !redirect;
  assign push_write = push_req && !mispredict && ((count != FULL) || do_pop);
  assign err_set    = (resolve && (count == '0)) ||
                      (push_req && (count == FULL) && !do_pop);

  assign stall_req  = (count == FULL);

  always_ff @(posedge clk) begin
    if (push_write) begin
      alt_mem[wr_ptr] <= alt_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
      br_cnt      <= '0;
      miss_cnt    <= '0;
    end else begin
      redirect    <= mispredict;
      flush       <= mispredict;
      redirect_pc <= mispredict ? alt_mem[rd_ptr] : '0;

      if (err_set) begin
        err <= 1'b1;
      end
      if (do_pop && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CW'(1);
      end
      if (mispredict && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CW'(1);
      end

      // A mispredict squashes every younger logged branch, including this cycle's push.
      if (mispredict) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push_write) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push_write && !do_pop) begin
          count <= count + (PW+1)'(1);
        end else if (!push_write && do_pop) begin
          count <= count - (PW+1)'(1);
        end
      end
    end
  end

endmodule
